// File: rtl/wb_regfile.sv
// Writeback stage: selects write data, updates a 16-entry register file, serves two decode read
// ports, resolves ret/HALT at retirement and counts retired instructions. Optional WB_BYPASS_EN.
module wb_regfile #(
    parameter  int unsigned DATA_W  = 16,
    parameter  int unsigned NREGS   = 16,
    parameter  int unsigned RET_REG = 15,
    parameter  int unsigned CNT_W   = 32,
    localparam int unsigned ADDR_W  = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              RegWrite_in,
    input  logic              ret_in,
    input  logic              mem_to_reg_in,
    input  logic [ADDR_W-1:0] reg_rd_in,
    input  logic [DATA_W-1:0] mem_read_data_in,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic              HALT_in,
    input  logic [ADDR_W-1:0] rd_addr0,
    input  logic [ADDR_W-1:0] rd_addr1,
    output logic [DATA_W-1:0] rd_data0,
    output logic [DATA_W-1:0] rd_data1,
    output logic              ret_valid,
    output logic [DATA_W-1:0] ret_target,
    output logic              halted,
    output logic [CNT_W-1:0]  retired_cnt
);

    localparam logic [ADDR_W-1:0] RET_ADDR = ADDR_W'(RET_REG);
    localparam int unsigned       NPORTS   = 3;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              wr_en;
    logic              retire;
    logic              ret_fire;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] regs  [NREGS];
    logic [ADDR_W-1:0] raddr [NPORTS];
    logic [DATA_W-1:0] rdata [NPORTS];

    assign wdata = mem_to_reg_in ? mem_read_data_in : alu_result_in;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and retirement qualifiers; nothing retires once halted
    always_comb begin
        state_d  = state_q;
        wr_en    = 1'b0;
        retire   = 1'b0;
        ret_fire = 1'b0;
        case (state_q)
            RUN: begin
                wr_en    = RegWrite_in && (reg_rd_in != '0);
                retire   = RegWrite_in || ret_in || HALT_in;
                ret_fire = ret_in;
                if (HALT_in) begin
                    state_d = HALTED;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Port 2 is the internal return-address read, sharing the forwarding rule of the decode ports
    assign raddr[0] = rd_addr0;
    assign raddr[1] = rd_addr1;
    assign raddr[2] = RET_ADDR;

    always_comb begin
        for (int i = 0; i < int'(NPORTS); i++) begin
            rdata[i] = regs[raddr[i]];
            if (raddr[i] == '0) begin
                rdata[i] = '0;
            end
`ifdef WB_BYPASS_EN
            else if (wr_en && (raddr[i] == reg_rd_in)) begin
                rdata[i] = wdata;
            end
`endif
        end
    end

    assign rd_data0 = rdata[0];
    assign rd_data1 = rdata[1];
    assign halted   = (state_q == HALTED);

    // Register array; R0 is never written so it stays zero
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREGS); i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            regs[reg_rd_in] <= wdata;
        end
    end

    // Retirement outputs: ret pulse, captured return address, wrapping retire counter
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid   <= 1'b0;
            ret_target  <= '0;
            retired_cnt <= '0;
        end else begin
            ret_valid <= ret_fire;
            if (ret_fire) begin
                ret_target <= rdata[2];
            end
            if (retire) begin
                retired_cnt <= retired_cnt + CNT_W'(1);
            end
        end
    end

endmodule
